// File: rtl/logicop_exec_if.sv
// logicop_exec_if: operation type and valid/ready bus for the logic/shift execute unit
package logicop_pkg;
   typedef enum logic [2:0] {LOP_NOP, LOP_AND, LOP_ORR, LOP_XOR, LOP_SLL, LOP_SRL, LOP_SRA} rv32_logicop;
endpackage

interface logicop_exec_if;
   import logicop_pkg::*;
   logic        i_valid;
   logic        o_ready;
   rv32_logicop i_logicop;
   logic [31:0] i_op_a;
   logic [31:0] i_op_b;
   logic        o_valid;
   logic        i_ready;
   logic [31:0] o_result;
   logic        o_busy;
   modport master(output i_valid, i_logicop, i_op_a, i_op_b, i_ready, input o_ready, o_valid, o_result, o_busy);
   modport slave(input i_valid, i_logicop, i_op_a, i_op_b, i_ready, output o_ready, o_valid, o_result, o_busy);
endinterface

// File: rtl/logicop_exec.sv
// logicop_exec: bitwise ops in one cycle, shifts iterated SHIFT_STEP bits per cycle
module logicop_exec
   import logicop_pkg::*;
#(
   parameter int SHIFT_STEP = 4
) (
   input logic            i_clk,
   input logic            i_rst_n,
   input logic            i_flush,
   logicop_exec_if.slave  bus
);
   if (!(SHIFT_STEP inside {1, 2, 4, 8, 16, 32})) begin : g_bad_step
      $error("SHIFT_STEP must be a power of 2 in 1..32");
   end
   localparam logic [5:0] STEP = 6'(SHIFT_STEP);
   typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
   state_t      state;
   rv32_logicop op;
   logic [31:0] acc;
   logic [5:0]  rem;
   logic [5:0]  step;
   logic [31:0] shifted;
   logic [31:0] quick;
   logic        is_shift;
   logic        accept;
   assign bus.o_ready = !i_flush && (state == IDLE || (state == DONE && bus.i_ready));
   assign bus.o_valid = state == DONE;
   assign bus.o_busy  = state == SHIFT;
   assign accept      = bus.i_valid && bus.o_ready;
   assign is_shift    = bus.i_logicop inside {LOP_SLL, LOP_SRL, LOP_SRA};
   // one partial shift per cycle, and the single-cycle result of a newly accepted op
   always_comb begin
      step    = rem < STEP ? rem : STEP;
      shifted = op == LOP_SLL ? acc << step :
                op == LOP_SRA ? 32'($signed(acc) >>> step) : acc >> step;
      quick   = bus.i_logicop == LOP_AND ? bus.i_op_a & bus.i_op_b :
                bus.i_logicop == LOP_ORR ? bus.i_op_a | bus.i_op_b :
                bus.i_logicop == LOP_XOR ? bus.i_op_a ^ bus.i_op_b :
                is_shift ? bus.i_op_a : 32'h0;
   end
   // state machine; o_result is only loaded on entry to DONE
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state        <= IDLE;
         op           <= LOP_NOP;
         acc          <= '0;
         rem          <= '0;
         bus.o_result <= '0;
      end else if (i_flush) begin
         state <= IDLE;
      end else if (accept) begin
         op  <= bus.i_logicop;
         acc <= bus.i_op_a;
         rem <= {1'b0, bus.i_op_b[4:0]};
         if (is_shift && bus.i_op_b[4:0] != 5'd0) begin
            state <= SHIFT;
         end else begin
            state        <= DONE;
            bus.o_result <= quick;
         end
      end else if (state == SHIFT) begin
         acc <= shifted;
         rem <= rem - step;
         if (rem == step) begin
            state        <= DONE;
            bus.o_result <= shifted;
         end
      end else if (state == DONE && bus.i_ready) begin
         state <= IDLE;
      end
   end
endmodule

// File: tb/tb_logicop_exec.sv
// tb_logicop_exec: directed vectors for the logic/shift execute unit
module tb_logicop_exec;
   import logicop_pkg::*;
   logic clk = 0;
   logic rst_n = 0;
   logic flush = 0;
   int   total = 0;
   int   bad = 0;
   logicop_exec_if bus();
   logicop_exec #(.SHIFT_STEP(4)) dut (.i_clk(clk), .i_rst_n(rst_n), .i_flush(flush), .bus(bus));
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic issue(input rv32_logicop op, input logic [31:0] a, input logic [31:0] b);
      bus.i_logicop = op;
      bus.i_op_a    = a;
      bus.i_op_b    = b;
      bus.i_valid   = 1;
      @(posedge clk);
      #1;
      bus.i_valid = 0;
   endtask

   task automatic run_op(input string tag, input rv32_logicop op, input logic [31:0] a, input logic [31:0] b,
                         input int exp_cycles, input logic [31:0] exp_res);
      int n = 0;
      issue(op, a, b);
      if (exp_cycles > 0) chk({tag, "_ready_in_shift"}, 32'(bus.o_ready), 32'd0);
      while (bus.o_busy && n < 50) begin
         @(posedge clk);
         #1;
         n++;
      end
      chk({tag, "_cycles"}, 32'(n), 32'(exp_cycles));
      chk({tag, "_valid"}, 32'(bus.o_valid), 32'd1);
      chk({tag, "_result"}, bus.o_result, exp_res);
      @(posedge clk);
      #1;
      chk({tag, "_idle"}, 32'(bus.o_valid), 32'd0);
   endtask

   initial begin
      bus.i_valid   = 0;
      bus.i_ready   = 1;
      bus.i_logicop = LOP_NOP;
      bus.i_op_a    = 0;
      bus.i_op_b    = 0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_valid", 32'(bus.o_valid), 32'd0);
      chk("rst_result", bus.o_result, 32'h0);
      chk("rst_busy", 32'(bus.o_busy), 32'd0);
      chk("rst_ready", 32'(bus.o_ready), 32'd1);
      rst_n = 1;
      @(posedge clk);
      #1;
      issue(LOP_AND, 32'hF0F0_1234, 32'h0FF0_FFFF);
      chk("and_valid", 32'(bus.o_valid), 32'd1);
      chk("and_result", bus.o_result, 32'h00F0_1234);
      chk("and_ready", 32'(bus.o_ready), 32'd1);
      issue(LOP_XOR, 32'h1234_5678, 32'hFFFF_0000);
      chk("xor_valid", 32'(bus.o_valid), 32'd1);
      chk("xor_result", bus.o_result, 32'hEDCB_5678);
      @(posedge clk);
      #1;
      chk("xor_idle", 32'(bus.o_valid), 32'd0);
      run_op("sll5", LOP_SLL, 32'h0000_0001, 32'h0000_0005, 2, 32'h0000_0020);
      run_op("sra31", LOP_SRA, 32'h8000_0000, 32'h0000_001F, 8, 32'hFFFF_FFFF);
      run_op("srl31", LOP_SRL, 32'h8000_0000, 32'h0000_001F, 8, 32'h0000_0001);
      run_op("sll31", LOP_SLL, 32'h0000_0003, 32'h0000_001F, 8, 32'h8000_0000);
      run_op("sra16", LOP_SRA, 32'h7FFF_0000, 32'h0000_0010, 4, 32'h0000_7FFF);
      run_op("srl0", LOP_SRL, 32'hDEAD_BEEF, 32'hFFFF_FFE0, 0, 32'hDEAD_BEEF);
      run_op("nop", LOP_NOP, 32'hDEAD_BEEF, 32'h1234_5678, 0, 32'h0000_0000);
      bus.i_ready = 0;
      issue(LOP_ORR, 32'hA0A0_A0A0, 32'h0505_0505);
      bus.i_logicop = LOP_AND;
      bus.i_op_a    = 32'hFFFF_FFFF;
      bus.i_op_b    = 32'h0;
      bus.i_valid   = 1;
      for (int i = 0; i < 5; i++) begin
         chk("bp_valid", 32'(bus.o_valid), 32'd1);
         chk("bp_result", bus.o_result, 32'hA5A5_A5A5);
         chk("bp_ready", 32'(bus.o_ready), 32'd0);
         @(posedge clk);
         #1;
      end
      bus.i_valid = 0;
      bus.i_ready = 1;
      @(posedge clk);
      #1;
      chk("bp_idle", 32'(bus.o_valid), 32'd0);
      issue(LOP_SLL, 32'h0000_0001, 32'h0000_001F);
      @(posedge clk);
      #1;
      flush = 1;
      bus.i_logicop = LOP_AND;
      bus.i_op_a    = 32'hFFFF_FFFF;
      bus.i_op_b    = 32'hFFFF_FFFF;
      bus.i_valid   = 1;
      #1;
      chk("flush_ready", 32'(bus.o_ready), 32'd0);
      @(posedge clk);
      #1;
      flush = 0;
      bus.i_valid = 0;
      chk("flush_busy", 32'(bus.o_busy), 32'd0);
      chk("flush_valid", 32'(bus.o_valid), 32'd0);
      repeat (10) begin
         @(posedge clk);
         #1;
         chk("flush_no_valid", 32'(bus.o_valid), 32'd0);
      end
      run_op("post_flush", LOP_SRL, 32'h0000_0080, 32'h0000_0003, 1, 32'h0000_0010);
      issue(LOP_SRA, 32'h8000_0000, 32'h0000_0010);
      @(posedge clk);
      #2;
      rst_n = 0;
      #1;
      chk("arst_busy", 32'(bus.o_busy), 32'd0);
      chk("arst_valid", 32'(bus.o_valid), 32'd0);
      chk("arst_result", bus.o_result, 32'h0);
      #1;
      rst_n = 1;
      repeat (6) begin
         @(posedge clk);
         #1;
         chk("arst_no_valid", 32'(bus.o_valid), 32'd0);
      end
      run_op("post_rst", LOP_SRA, 32'hF000_0000, 32'h0000_0004, 1, 32'hFF00_0000);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
